ram_port_master: RTL and testbench
==================================

// Module: ram_port_master
// PURPOSE
//  Initiator for one port (A or B) of the dual-port 2KB RAM.
//  - Accepts read/write commands on a valid/ready interface.
//  - Drives the RAM port: wr_en/rd_en, address, write data.
//  - Waits for the RAM's wr_ack, or for the configured read latency.
//  - Returns one response per command on a valid/ready interface.
//  One instance per RAM port; sits between client logic and the RAM.
// PARAMETERS
//  ADDR_W      11  RAM address width (2048 locations)
//  DATA_W      8   RAM data width
//  RD_LATENCY  1   cycles from the rd_en cycle to valid ram_rd_data; legal range 1..4
//  ACK_TIMEOUT 15  max WAIT_ACK cycles before error (used only with ACK_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock; all logic on the rising edge
//  reset        in   1       asynchronous, active-low reset (0 = in reset)
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       block accepts a command this cycle
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  command address
//  cmd_wdata    in   DATA_W  write data; ignored for reads
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       client consumes the response
//  rsp_write    out  1       echo of cmd_write for this response
//  rsp_rdata    out  DATA_W  read data; 0 for writes
//  rsp_err      out  1       write-ack timeout; tied 0 without ACK_TIMEOUT_EN
//  busy         out  1       state != IDLE
//  ram_wr_en    out  1       RAM write strobe
//  ram_rd_en    out  1       RAM read strobe
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_wr_ack   in   1       RAM write acknowledge
//  ram_rd_data  in   DATA_W  RAM read data
// BEHAVIOUR
//  - Reset: async clear of every output and register to 0; state = IDLE.
//    - Asserting reset mid-transaction drops ram_wr_en/ram_rd_en immediately.
//    - The in-flight command is discarded; no response is produced.
//  - FSM states: IDLE, WR, WAIT_ACK, RD, RD_WAIT, RSP.
//  - cmd_ready = (state==IDLE). Handshake = cmd_valid & cmd_ready.
//    - On the handshake, latch addr/wdata/write.
//    - Next state is WR if cmd_write=1, else RD.
//    - cmd_* is ignored when cmd_ready=0.
//  - ram_addr and ram_wdata are held at the latched values from WR/RD through RSP.
//    - Both return to 0 in IDLE.
//    - ram_addr is passed through as-is; no address arithmetic or wrap.
//  - WR: ram_wr_en=1 for exactly one cycle.
//    - If ram_wr_ack=1 in this cycle, go to RSP; otherwise go to WAIT_ACK.
//  - WAIT_ACK: ram_wr_en=0; go to RSP on the first cycle with ram_wr_ack=1.
//  - ram_wr_ack is ignored in every state except WR and WAIT_ACK.
//  - RD: ram_rd_en=1 for exactly one cycle, then go to RD_WAIT.
//  - RD_WAIT: lasts RD_LATENCY cycles.
//    - ram_rd_data is registered into rsp_rdata on the edge ending the last RD_WAIT cycle.
//    - Then go to RSP.
//  - RSP: rsp_valid=1.
//    - rsp_write, rsp_rdata and rsp_err stay stable until rsp_ready=1.
//    - The cycle with rsp_ready=1 completes the response; next state is IDLE.
//    - rsp_valid and cmd_ready are never both 1.
//  - Minimum command-to-command spacing:
//    - write, ack in WR cycle: 3 cycles (WR, RSP, IDLE);
//    - read: RD_LATENCY+3 cycles.
// CONFIGURATION
//  - ACK_TIMEOUT_EN defined:
//    - WAIT_ACK counts cycles; the counter clears on entry to WR.
//    - After ACK_TIMEOUT consecutive WAIT_ACK cycles without an ack, go to RSP with rsp_err=1.
//    - A late ack after that point is ignored.
//  - ACK_TIMEOUT_EN undefined:
//    - No counter; WAIT_ACK waits indefinitely.
//    - rsp_err is constant 0.
// TESTING
//  1. Write addr 10, data 0x4B; ack one cycle after WR.
//     -> ram_wr_en high one cycle with ram_addr=10, ram_wdata=0x4B.
//     -> rsp_valid=1, rsp_write=1, rsp_err=0.
//  2. Read addr 10 (RAM model holds 0x4B, RD_LATENCY=1).
//     -> ram_rd_en high one cycle; rsp_rdata=0x4B, rsp_write=0.
//  3. Hold rsp_ready=0 for 5 cycles while cmd_valid=1.
//     -> rsp_* stable, cmd_ready=0, no second command accepted.
//     -> After rsp_ready=1, cmd_ready=1 on the next cycle.
//  4. Assert reset in WAIT_ACK.
//     -> ram_wr_en=0, rsp_valid=0, busy=0 with no clock edge needed.
//     -> After release, cmd_ready=1 and a read of addr 20 completes normally.
//  5. Write addr 100, data 0xAA, ram_wr_ack held 0.
//     -> With macro: rsp_err=1 after 15 WAIT_ACK cycles.
//     -> Without macro: busy stays 1, rsp_valid stays 0.
//  6. RD_LATENCY=2, read addr 101 (model holds 0xDD).
//     -> Data is captured 2 cycles after the ram_rd_en cycle; rsp_rdata=0xDD.

Source files
------------

// File: rtl/ram_port_master.sv
// Single-port initiator for the dual-port RAM: valid/ready command in, RAM strobes out, one response per command.
// Optional write-ack timeout is compiled in with `define ACK_TIMEOUT_EN.
module ram_port_master #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int RD_LATENCY  = 1
`ifdef ACK_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_wr_ack,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_ACK,
        RD,
        RD_WAIT,
        RSP
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;
    logic [2:0]        lat_cnt;
    logic              accept;
    logic              lat_done;
    logic              timeout;

    assign accept    = cmd_valid & cmd_ready;
    assign lat_done  = (lat_cnt == LAT_LAST);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign ram_addr  = (state != IDLE) ? addr_q  : '0;
    assign ram_wdata = (state != IDLE) ? wdata_q : '0;

`ifdef ACK_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] ack_cnt;
    logic             err_q;

    assign timeout = (ack_cnt == TO_LAST);
    assign rsp_err = err_q;

    // Counts WAIT_ACK cycles of the current write; the error flag is sticky until the next command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept && cmd_write) begin
                ack_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (state == WAIT_ACK && !ram_wr_ack && timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture and read-latency tracking; read data lands on the edge ending the last RD_WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            lat_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_write ? cmd_wdata : '0;
                write_q <= cmd_write;
                rdata_q <= '0;
            end
            if (state == RD) begin
                lat_cnt <= '0;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (state == RD_WAIT && lat_done) begin
                rdata_q <= ram_rd_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ram_wr_en  = 1'b0;
        ram_rd_en  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0 in reset.
                cmd_ready = reset;
                if (cmd_valid && reset) begin
                    state_next = cmd_write ? WR : RD;
                end
            end
            WR: begin
                ram_wr_en  = 1'b1;
                state_next = ram_wr_ack ? RSP : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ram_wr_ack || timeout) begin
                    state_next = RSP;
                end
            end
            RD: begin
                ram_rd_en  = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_done) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: cycle-by-cycle comparison against a transaction-timeline model,
// plus directed literal checks; DUT2 runs with RD_LATENCY=2.
module tb_ram_port_master;

    localparam int ACK_TO = 15;

    logic        clk;
    logic        reset;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
    logic [7:0]  rsp_rdata;
    logic        ram_wr_en, ram_rd_en, ram_wr_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rd_data;

    logic        cmd_valid2, cmd_ready2, cmd_write2;
    logic [10:0] cmd_addr2;
    logic [7:0]  cmd_wdata2;
    logic        rsp_valid2, rsp_ready2, rsp_write2, rsp_err2, busy2;
    logic [7:0]  rsp_rdata2;
    logic        ram_wr_en2, ram_rd_en2, ram_wr_ack2;
    logic [10:0] ram_addr2;
    logic [7:0]  ram_wdata2, ram_rd_data2;
    logic        rd2_stage;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem1 [2048];
    logic [7:0] mem2 [2048];
    int         since_wr;
    int         ack_delay;
    logic       ack_en, ack_force;

    ram_port_master #(.ADDR_W(11), .DATA_W(8), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wr_ack(ram_wr_ack), .ram_rd_data(ram_rd_data)
    );

    ram_port_master #(.ADDR_W(11), .DATA_W(8), .RD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write2),
        .cmd_addr(cmd_addr2), .cmd_wdata(cmd_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_write(rsp_write2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
        .ram_wr_en(ram_wr_en2), .ram_rd_en(ram_rd_en2), .ram_addr(ram_addr2),
        .ram_wdata(ram_wdata2), .ram_wr_ack(ram_wr_ack2), .ram_rd_data(ram_rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behaviour: ack ack_delay cycles after the write strobe (0 = same cycle), data valid only in its latency slot.
    assign ram_wr_ack = ack_force | (ack_en & ((ack_delay == 0) ? ram_wr_en : (since_wr == ack_delay)));

    always @(posedge clk or negedge reset) begin
        if (!reset) since_wr <= 0;
        else if (ram_wr_en) since_wr <= 1;
        else if (since_wr != 0 && since_wr < 1000) since_wr <= since_wr + 1;
    end

    always @(posedge clk) begin
        if (ram_wr_en) mem1[ram_addr] <= ram_wdata;
        ram_rd_data  <= ram_rd_en ? mem1[ram_addr] : 8'h00;
        rd2_stage    <= ram_rd_en2;
        ram_rd_data2 <= rd2_stage ? mem2[ram_addr2] : 8'h00;
    end

    // Transaction model: age counts cycles since acceptance; age 0 is the strobe cycle.
    logic        m_active, m_write, m_started, m_err;
    logic [10:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    int          m_age;
    logic [7:0]  m_mem [2048];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active  = 1'b0;
            m_started = 1'b0;
            m_err     = 1'b0;
            m_age     = 0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active  = 1'b1;
                m_age     = 0;
                m_write   = cmd_write;
                m_addr    = cmd_addr;
                m_wdata   = cmd_wdata;
                m_started = 1'b0;
                m_err     = 1'b0;
                m_rdata   = 8'h00;
            end
        end else if (m_started) begin
            if (rsp_ready) m_active = 1'b0;
        end else begin
            if (m_write) begin
                if (m_age == 0) m_mem[m_addr] = m_wdata;
                if (ram_wr_ack) m_started = 1'b1;
`ifdef ACK_TIMEOUT_EN
                else if (m_age == ACK_TO) begin
                    m_started = 1'b1;
                    m_err     = 1'b1;
                end
`endif
            end else if (m_age == 1) begin
                m_rdata   = m_mem[m_addr];
                m_started = 1'b1;
            end
            m_age = m_age + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("m_busy", busy, m_active);
            checkOutput("m_cmd_ready", cmd_ready, !m_active);
            checkOutput("m_rsp_valid", rsp_valid, m_active && m_started);
            checkOutput("m_ram_wr_en", ram_wr_en, m_active && m_write && m_age == 0);
            checkOutput("m_ram_rd_en", ram_rd_en, m_active && !m_write && m_age == 0);
            checkOutput("m_ram_addr", ram_addr, m_active ? 32'(m_addr) : 32'd0);
            if (m_active && m_write) checkOutput("m_ram_wdata", ram_wdata, m_wdata);
            if (m_active && m_started) begin
                checkOutput("m_rsp_write", rsp_write, m_write);
                checkOutput("m_rsp_rdata", rsp_rdata, m_write ? 8'h00 : m_rdata);
                checkOutput("m_rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic w, input logic [10:0] a, input logic [7:0] d);
        logic hs;
        hs        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", hs, 1);
    endtask

    task automatic applyStimulus(input logic w, input logic [10:0] a, input logic [7:0] d,
                                 output logic rw, output logic [7:0] rd, output logic re);
        logic got;
        got = 1'b0;
        rw  = 1'b0;
        rd  = 8'h00;
        re  = 1'b0;
        sendCmd(w, a, d);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                rw  = rsp_write;
                rd  = rsp_rdata;
                re  = rsp_err;
            end
            tick();
        end
        checkOutput("rsp_seen", got, 1);
    endtask

    task automatic waitIdle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            if (!idle) tick();
        end
        checkOutput("wait_idle", idle, 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [10:0] bnd_addr [4];
    logic [7:0]  bnd_data [4];
    logic        rw, re;
    logic [7:0]  rd;
    int          n;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i]  = 8'h00;
            mem2[i]  = 8'h00;
            m_mem[i] = 8'h00;
        end
        mem2[101] = 8'hDD;
        bnd_addr  = '{11'd0, 11'd2047, 11'd1024, 11'd1234};
        bnd_data  = '{8'hFF, 8'h01, 8'h80, 8'h00};
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = '0; cmd_wdata2 = '0; rsp_ready2 = 1'b1;
        ram_wr_ack2 = 1'b0;
        ack_en = 1'b1; ack_delay = 1; ack_force = 1'b0;

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_wr_en", ram_wr_en, 0);
        checkOutput("rst_rd_en", ram_rd_en, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        #10 reset = 1'b1;
        tick();

        $display("[TB] write addr 10 data 4B, ack one cycle after WR");
        sendCmd(1'b1, 11'd10, 8'h4B);
        @(negedge clk);
        checkOutput("t1_wr_en", ram_wr_en, 1);
        checkOutput("t1_addr", ram_addr, 10);
        checkOutput("t1_wdata", ram_wdata, 8'h4B);
        tick(); @(negedge clk);
        checkOutput("t1_wr_en_drop", ram_wr_en, 0);
        checkOutput("t1_no_rsp_yet", rsp_valid, 0);
        tick(); @(negedge clk);
        checkOutput("t1_rsp_valid", rsp_valid, 1);
        checkOutput("t1_rsp_write", rsp_write, 1);
        checkOutput("t1_rsp_err", rsp_err, 0);
        tick(); @(negedge clk);
        checkOutput("t1_cmd_ready", cmd_ready, 1);
        tick();

        $display("[TB] read addr 10 with a stray ack held high");
        ack_force = 1'b1;
        sendCmd(1'b0, 11'd10, 8'h00);
        @(negedge clk);
        checkOutput("t2_rd_en", ram_rd_en, 1);
        checkOutput("t2_addr", ram_addr, 10);
        tick(); @(negedge clk);
        checkOutput("t2_rd_en_drop", ram_rd_en, 0);
        checkOutput("t2_no_rsp_yet", rsp_valid, 0);
        tick(); @(negedge clk);
        checkOutput("t2_rsp_valid", rsp_valid, 1);
        checkOutput("t2_rsp_rdata", rsp_rdata, 8'h4B);
        checkOutput("t2_rsp_write", rsp_write, 0);
        tick();
        ack_force = 1'b0;

        $display("[TB] response backpressure with a pending command");
        ack_delay = 0;
        rsp_ready = 1'b0;
        sendCmd(1'b1, 11'd30, 8'h5A);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'd31; cmd_wdata = 8'h77;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_rsp_valid", rsp_valid, 1);
            checkOutput("t3_cmd_ready", cmd_ready, 0);
            checkOutput("t3_rsp_write", rsp_write, 1);
            checkOutput("t3_no_strobe", ram_wr_en, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick(); @(negedge clk);
        checkOutput("t3_cmd_ready_after", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        waitIdle();
        applyStimulus(1'b0, 11'd31, 8'h00, rw, rd, re);
        checkOutput("t3_rd31", rd, 8'h77);
        applyStimulus(1'b0, 11'd30, 8'h00, rw, rd, re);
        checkOutput("t3_rd30", rd, 8'h5A);

        $display("[TB] reset during WAIT_ACK and during RD");
        ack_en = 1'b0;
        sendCmd(1'b1, 11'd50, 8'h11);
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("t4_wr_en", ram_wr_en, 0);
        checkOutput("t4_rsp_valid", rsp_valid, 0);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_addr", ram_addr, 0);
        #3 reset = 1'b1;
        tick(); @(negedge clk);
        checkOutput("t4_cmd_ready", cmd_ready, 1);
        tick();
        sendCmd(1'b0, 11'd60, 8'h00);
        @(negedge clk);
        checkOutput("t4b_rd_en", ram_rd_en, 1);
        #1 reset = 1'b0;
        #1;
        checkOutput("t4b_rd_en_drop", ram_rd_en, 0);
        checkOutput("t4b_busy", busy, 0);
        #1 reset = 1'b1;
        tick();
        ack_en = 1'b1; ack_delay = 1;
        applyStimulus(1'b1, 11'd20, 8'h3C, rw, rd, re);
        checkOutput("t4_wr20_write", rw, 1);
        applyStimulus(1'b0, 11'd20, 8'h00, rw, rd, re);
        checkOutput("t4_rd20", rd, 8'h3C);
        checkOutput("t4_rd20_write", rw, 0);

        $display("[TB] boundary addresses and ack delays");
        for (int i = 0; i < 3; i++) begin
            ack_delay = (i == 0) ? 0 : i + 1;
            applyStimulus(1'b1, bnd_addr[i], bnd_data[i], rw, rd, re);
            checkOutput("bnd_wr_write", rw, 1);
            checkOutput("bnd_wr_rdata", rd, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, bnd_addr[i], 8'h00, rw, rd, re);
            checkOutput("bnd_rd_data", rd, bnd_data[i]);
        end

        $display("[TB] write with ack never arriving");
        ack_en = 1'b0;
        sendCmd(1'b1, 11'd100, 8'hAA);
        n = 0;
`ifdef ACK_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
            tick();
        end
        checkOutput("t5_cycles_to_rsp", n, 16);
        checkOutput("t5_rsp_err", rsp_err, 1);
        tick();
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        waitIdle();
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && !rsp_valid) n++;
            tick();
        end
        checkOutput("t5_stuck_cycles", n, 40);
        checkOutput("t5_busy", busy, 1);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        @(negedge clk);
        checkOutput("t5_rsp_after_ack", rsp_valid, 1);
        checkOutput("t5_rsp_err", rsp_err, 0);
        tick();
        waitIdle();
`endif
        ack_en = 1'b1; ack_delay = 1;

        $display("[TB] RD_LATENCY=2 read of addr 101");
        cmd_valid2 = 1'b1; cmd_write2 = 1'b0; cmd_addr2 = 11'd101;
        tick();
        cmd_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("t6_rd_en", ram_rd_en2, 1);
        checkOutput("t6_addr", ram_addr2, 101);
        tick(); @(negedge clk);
        checkOutput("t6_wait1", rsp_valid2, 0);
        tick(); @(negedge clk);
        checkOutput("t6_wait2", rsp_valid2, 0);
        checkOutput("t6_busy", busy2, 1);
        tick(); @(negedge clk);
        checkOutput("t6_rsp_valid", rsp_valid2, 1);
        checkOutput("t6_rsp_rdata", rsp_rdata2, 8'hDD);
        checkOutput("t6_rsp_write", rsp_write2, 0);
        tick(); @(negedge clk);
        checkOutput("t6_idle", busy2, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
